fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   IF stage plus IF/ID pipeline register of the 5-stage RV32I core. Holds PCF, drives the
//   synchronous instruction memory and presents InstrD/PCD/PCPlus4D to decode.
//   Consumes StallF, StallD and FlushD from the hazard unit, and the branch/jump redirect
//   (PCSrcE, PCTargetE) from execute.
//   Keeps a stalled instruction intact across a 1-cycle-latency synchronous memory read.
// PARAMETERS
//   XLEN      32            address/PC width
//   RESET_PC  32'h0000_0000 PCF value after reset
//   NOP_INSTR 32'h0000_0013 addi x0,x0,0 injected into decode on flush/reset
// PORTS
//   clk         in   1     single clock, rising edge
//   reset       in   1     synchronous, active-high
//   StallF      in   1     hold PCF
//   StallD      in   1     hold IF/ID register
//   FlushD      in   1     squash IF/ID contents
//   PCSrcE      in   1     redirect taken in execute
//   PCTargetE   in   XLEN  redirect target
//   imem_addr   out  XLEN  = PCF (combinational)
//   imem_rdata  in   32    word at imem_addr sampled on previous edge (1-cycle read latency)
//   InstrD      out  32    decode instruction
//   PCD         out  XLEN  PC of InstrD
//   PCPlus4D    out  XLEN  PCD+4
//   ValidD      out  1     InstrD is a real (non-bubble) instruction
// BEHAVIOUR
//   Reset (sync, dominates all): PCF<=RESET_PC; PCD<=0; PCPlus4D<=0; ValidD<=0;
//     bubble_q<=1 (so InstrD=NOP_INSTR); use_hold_q<=0; instr_hold<=NOP_INSTR.
//   PCF next, priority order: PCSrcE -> {PCTargetE[XLEN-1:2],2'b00} (beats StallF; branch is older);
//     StallF -> PCF; else PCF+4, wrapping mod 2^XLEN (32'hFFFF_FFFC -> 0).
//   PCPlus4F = PCF+4, same wrap. imem_addr = PCF every cycle; memory read always enabled.
//   IF/ID next, priority order: FlushD -> PCD<=0, PCPlus4D<=0, ValidD<=0, bubble_q<=1;
//     StallD -> all IF/ID regs hold; else PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1, bubble_q<=0.
//   FlushD beats StallD when both are high (load-use stall coincident with taken branch).
//   InstrD mux: bubble_q -> NOP_INSTR; else use_hold_q -> instr_hold; else imem_rdata.
//   Hold path: each edge with StallD=1 and FlushD=0: instr_hold<=InstrD (current mux output),
//     use_hold_q<=1. Any edge with StallD=0 or FlushD=1: use_hold_q<=0.
//     Multi-cycle stalls keep the same word; the memory output may change under a stall.
//   Latency: fetch at PCF in cycle n -> InstrD/PCD valid in cycle n+1 absent stall/flush.
//   Redirect: PCSrcE in cycle n -> PCF=target in n+1; InstrD in n+1 is NOP (FlushD in n);
//     target instruction reaches decode in n+2.
//   StallF=1 with StallD=0 is not a legal hazard-unit output.
//     Defined anyway: PCF holds, and the same PC is re-latched into decode every cycle.
//   Width: all PC arithmetic is XLEN-bit unsigned; carry out is discarded.
// STRUCTURE
//   riscv_pkg: NOP_INSTR, RESET_PC, XLEN constants (shared with decode/hazard logic).
//   One sub-module: pipe_reg_en_clr #(W, RST_VAL). Generic register with enable (=~stall)
//     and synchronous clear (=flush|reset).
//     Used for PCF (clear unused), PCD/PCPlus4D and the ValidD/bubble flags.
//   Hold register, use_hold flag and InstrD mux are local to this module.
// TESTING
//   1. Reset held 2 cycles, then released, imem returns PC-indexed words
//      -> PCF=0,4,8...; InstrD=0x13 during reset and the first cycle after.
//   2. Straight-line run, mem[0x8]=0x00A00093 -> InstrD=0x00A00093, PCD=0x8,
//      PCPlus4D=0xC, ValidD=1 one cycle after PCF=0x8.
//   3. StallF=StallD=1 for 3 cycles with InstrD=0x00A00093 while imem_rdata changes
//      -> PCF/PCD frozen, InstrD stays 0x00A00093, resumes with the next PC.
//   4. PCSrcE=1, FlushD=1, PCTargetE=0x0000_0102 -> next PCF=0x100; InstrD=0x13,
//      ValidD=0 for one cycle; then PCD=0x100.
//   5. StallF=StallD=FlushD=PCSrcE=1 simultaneously, PCTargetE=0x40 -> PCF=0x40,
//      IF/ID bubble, use_hold cleared; PCD=0x40 two cycles later.
//   6. PCF=0xFFFF_FFFC, no stall -> PCPlus4D=0, next PCF=0;
//      assert reset mid-stall -> all outputs at reset values next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide constants shared by fetch, decode and hazard logic
package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr: pipeline register with enable and synchronous clear to RST_VAL
module pipe_reg_en_clr #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk)
        if (clr_i) q_o <= RST_VAL;
        else if (en_i) q_o <= d_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, synchronous imem interface and IF/ID pipeline register
module fetch_stage #(
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);
    import riscv_pkg::*;
    logic [XLEN-1:0] pcf_q, pcf_d, pcplus4f;
    logic            bubble_q, use_hold_q, use_hold_d;
    logic [31:0]     instr_hold_q, instr_hold_d;
    assign pcplus4f  = pcf_q + XLEN'(4);
    assign pcf_d     = PCSrcE ? {PCTargetE[XLEN-1:2], 2'b00} : pcplus4f;
    assign imem_addr = pcf_q;
    // A taken redirect is older than the stall, so it still loads the PC.
    pipe_reg_en_clr #(.W(XLEN), .RST_VAL(RESET_PC[XLEN-1:0])) u_pcf (
        .clk(clk), .en_i(~StallF | PCSrcE), .clr_i(reset), .d_i(pcf_d), .q_o(pcf_q)
    );
    pipe_reg_en_clr #(.W(2*XLEN), .RST_VAL('0)) u_pcd (
        .clk(clk), .en_i(~StallD), .clr_i(FlushD | reset),
        .d_i({pcf_q, pcplus4f}), .q_o({PCD, PCPlus4D})
    );
    pipe_reg_en_clr #(.W(2), .RST_VAL(2'b01)) u_flags (
        .clk(clk), .en_i(~StallD), .clr_i(FlushD | reset),
        .d_i(2'b10), .q_o({ValidD, bubble_q})
    );
    // The memory keeps reading under a stall, so the decoded word is captured locally.
    always_comb begin
        InstrD       = bubble_q ? NOP_INSTR : use_hold_q ? instr_hold_q : imem_rdata;
        use_hold_d   = StallD & ~FlushD;
        instr_hold_d = use_hold_d ? InstrD : instr_hold_q;
    end
    always_ff @(posedge clk)
        if (reset) begin
            use_hold_q   <= 1'b0;
            instr_hold_q <= NOP_INSTR;
        end else begin
            use_hold_q   <= use_hold_d;
            instr_hold_q <= instr_hold_d;
        end
endmodule
